// File: rtl/ibex_lsu_resp_pkg.sv
// Shared types for the LSU response stage: access size, response FSM states
// and the load-data extension helper.
package ibex_lsu_resp_pkg;

    typedef enum logic [1:0] {
        LSU_W = 2'b00,
        LSU_H = 2'b01,
        LSU_B = 2'b10
    } lsu_type_e;

    typedef enum logic [1:0] {
        IDLE          = 2'b00,
        WAIT_RESP     = 2'b01,
        WAIT_RESP_2ND = 2'b10
    } lsu_resp_state_e;

    // Keep the low byte/half/word and extend from its top bit when requested.
    function automatic logic [31:0] lsu_extend(input logic [31:0] data,
                                               input lsu_type_e   lsu_type,
                                               input logic        sign_ext);
        logic [31:0] ext_val;
        case (lsu_type)
            LSU_H:   ext_val = {{16{sign_ext & data[15]}}, data[15:0]};
            LSU_B:   ext_val = {{24{sign_ext & data[7]}}, data[7:0]};
            default: ext_val = data;
        endcase
        return ext_val;
    endfunction

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Combinational load-data aligner: shifts a single beat into place, or merges
// the pre-shifted first beat with the low bytes of the second beat.
module ibex_lsu_rdata_align
    import ibex_lsu_resp_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] rdata_q,
    input  lsu_type_e   lsu_type,
    input  logic [1:0]  offset,
    input  logic        split,
    input  logic        sign_ext,
    output logic [31:0] aligned
);

    logic [5:0]  shift_s;
    logic [5:0]  merge_shift_s;
    logic [31:0] raw_s;

    // rdata_q already holds the first beat shifted down; the second beat fills
    // the bytes above it. A 32-bit shift (offset 0) contributes nothing.
    always_comb begin
        shift_s       = {1'b0, offset, 3'b000};
        merge_shift_s = 6'd32 - shift_s;
        if (split) begin
            raw_s = rdata_q | (rdata << merge_shift_s);
        end else begin
            raw_s = rdata >> shift_s;
        end
        aligned = lsu_extend(raw_s, lsu_type, sign_ext);
    end

endmodule

// File: rtl/ibex_lsu_resp_chk.sv
// Protocol checks for the LSU response stage: no issue while not ready and
// no bus response without an outstanding transaction.
module ibex_lsu_resp_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic issue_valid_i,
    input logic issue_ready_o,
    input logic data_rvalid_i,
    input logic busy_o
);

    a_issue_when_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        issue_valid_i |-> issue_ready_o);

    a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_rvalid_i |-> busy_o);

endmodule

// File: rtl/ibex_lsu_resp.sv
// LSU response stage: tracks one outstanding load/store and reports its
// completion combinationally. Misaligned (two-beat) support: IBEX_LSU_MISALIGNED_EN.
module ibex_lsu_resp
    import ibex_lsu_resp_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        issue_valid_i,
    input  logic        issue_we_i,
    input  lsu_type_e   issue_type_i,
    input  logic        issue_sign_ext_i,
    input  logic [1:0]  issue_offset_i,
    input  logic        issue_split_i,
    output logic        issue_ready_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        busy_o
);

    lsu_resp_state_e state_r;
    lsu_resp_state_e issue_state_s;
    logic            we_r;
    lsu_type_e       type_r;
    logic            sign_ext_r;
    logic [1:0]      offset_r;
    logic            split_r;
    logic            err_r;
    logic [31:0]     rdata_q_s;
    logic            split_eff_s;
    logic            final_beat_s;
    logic            accept_s;
    logic            resp_err_s;
    logic [31:0]     aligned_s;

`ifdef IBEX_LSU_MISALIGNED_EN
    logic [31:0] rdata_q_r;
    assign rdata_q_s   = rdata_q_r;
    assign split_eff_s = split_r;
`else
    assign rdata_q_s   = 32'h0000_0000;
    assign split_eff_s = 1'b0;
`endif

    // Handshake and zero-latency response outputs for the instruction in flight.
    always_comb begin
        final_beat_s  = (state_r == WAIT_RESP) & data_rvalid_i;
        issue_ready_o = (state_r == IDLE) | final_beat_s;
        accept_s      = issue_valid_i & issue_ready_o;
`ifdef IBEX_LSU_MISALIGNED_EN
        resp_err_s    = err_r | data_err_i;
        if (issue_split_i) begin
            issue_state_s = WAIT_RESP_2ND;
        end else begin
            issue_state_s = WAIT_RESP;
        end
`else
        // Without misaligned support a split access can only end in error.
        resp_err_s    = err_r | data_err_i | split_r;
        issue_state_s = WAIT_RESP;
`endif
        lsu_resp_valid_o = final_beat_s;
        lsu_resp_err_o   = final_beat_s & resp_err_s;
        rf_we_lsu_o      = final_beat_s & ~we_r & ~resp_err_s;
        if (rf_we_lsu_o) begin
            rf_wdata_lsu_o = aligned_s;
        end else begin
            rf_wdata_lsu_o = 32'h0000_0000;
        end
        busy_o = (state_r != IDLE);
    end

    ibex_lsu_rdata_align u_align (
        .rdata    (data_rdata_i),
        .rdata_q  (rdata_q_s),
        .lsu_type (type_r),
        .offset   (offset_r),
        .split    (split_eff_s),
        .sign_ext (sign_ext_r),
        .aligned  (aligned_s)
    );

    // Response FSM plus the fields of the transaction it is tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            we_r       <= 1'b0;
            type_r     <= LSU_W;
            sign_ext_r <= 1'b0;
            offset_r   <= 2'b00;
            split_r    <= 1'b0;
            err_r      <= 1'b0;
`ifdef IBEX_LSU_MISALIGNED_EN
            rdata_q_r  <= 32'h0000_0000;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= issue_state_s;
                    end
                end
`ifdef IBEX_LSU_MISALIGNED_EN
                WAIT_RESP_2ND: begin
                    if (data_rvalid_i) begin
                        rdata_q_r <= data_rdata_i >> {offset_r, 3'b000};
                        err_r     <= err_r | data_err_i;
                        state_r   <= WAIT_RESP;
                    end
                end
`endif
                WAIT_RESP: begin
                    if (data_rvalid_i) begin
                        if (accept_s) begin
                            state_r <= issue_state_s;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
            // Issue is only accepted in IDLE or on a final beat, never while
            // a first beat is being captured, so this cannot clobber err_r.
            if (accept_s) begin
                we_r       <= issue_we_i;
                type_r     <= issue_type_i;
                sign_ext_r <= issue_sign_ext_i;
                offset_r   <= issue_offset_i;
                split_r    <= issue_split_i;
                err_r      <= 1'b0;
            end
        end
    end

    ibex_lsu_resp_chk u_chk (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .data_rvalid_i (data_rvalid_i),
        .busy_o        (busy_o)
    );

endmodule

// File: tb/tb_ibex_lsu_resp.sv
// Self-checking bench for ibex_lsu_resp: transaction-level model compared every
// cycle, plus directed vectors with literal expectations.
module tb_ibex_lsu_resp;
    import ibex_lsu_resp_pkg::*;

`ifdef IBEX_LSU_MISALIGNED_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic        issue_we_i;
    lsu_type_e   issue_type_i;
    logic        issue_sign_ext_i;
    logic [1:0]  issue_offset_i;
    logic        issue_split_i;
    logic        issue_ready_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    logic [31:0] rf_wdata_lsu_o;
    logic        rf_we_lsu_o;
    logic        lsu_resp_valid_o;
    logic        lsu_resp_err_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ibex_lsu_resp dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .issue_valid_i    (issue_valid_i),
        .issue_we_i       (issue_we_i),
        .issue_type_i     (issue_type_i),
        .issue_sign_ext_i (issue_sign_ext_i),
        .issue_offset_i   (issue_offset_i),
        .issue_split_i    (issue_split_i),
        .issue_ready_o    (issue_ready_o),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i),
        .data_err_i       (data_err_i),
        .rf_wdata_lsu_o   (rf_wdata_lsu_o),
        .rf_we_lsu_o      (rf_we_lsu_o),
        .lsu_resp_valid_o (lsu_resp_valid_o),
        .lsu_resp_err_o   (lsu_resp_err_o),
        .busy_o           (busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic        m_busy;
    int          m_beats;
    logic        m_we;
    lsu_type_e   m_type;
    logic        m_sext;
    logic [1:0]  m_off;
    logic        m_split;
    logic [31:0] m_first;
    logic        m_err;

    logic        exp_ready, exp_valid, exp_err, exp_we, exp_busy, e_err;
    logic [31:0] exp_wdata, load_val;
    logic [63:0] pair, pair_sh;

    function automatic logic [31:0] ext(input logic [31:0] v, input lsu_type_e t, input logic s);
        logic [31:0] r;
        r = v;
        if (t == LSU_B) begin
            r = v & 32'h0000_00FF;
            if (s && v[7]) r = r | 32'hFFFF_FF00;
        end else if (t == LSU_H) begin
            r = v & 32'h0000_FFFF;
            if (s && v[15]) r = r | 32'hFFFF_0000;
        end
        return r;
    endfunction

    always_comb begin
        exp_busy  = m_busy;
        exp_ready = !m_busy || (m_beats == 1 && data_rvalid_i);
        exp_valid = m_busy && (m_beats == 1) && data_rvalid_i;
        if (MIS && m_split) pair = {data_rdata_i, m_first};
        else                pair = {32'h0000_0000, data_rdata_i};
        pair_sh   = pair >> (8 * m_off);
        load_val  = ext(pair_sh[31:0], m_type, m_sext);
        e_err     = m_err || data_err_i || (m_split && !MIS);
        exp_err   = exp_valid && e_err;
        exp_we    = exp_valid && !m_we && !e_err;
        exp_wdata = exp_we ? load_val : 32'h0000_0000;
    end

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_busy  <= 1'b0;
            m_beats <= 0;
            m_we    <= 1'b0;
            m_type  <= LSU_W;
            m_sext  <= 1'b0;
            m_off   <= 2'b00;
            m_split <= 1'b0;
            m_first <= 32'h0000_0000;
            m_err   <= 1'b0;
        end else begin
            if (m_busy && data_rvalid_i) begin
                if (m_beats == 2) begin
                    m_first <= data_rdata_i;
                    m_err   <= m_err | data_err_i;
                    m_beats <= 1;
                end else begin
                    m_busy <= 1'b0;
                end
            end
            if (issue_valid_i && exp_ready) begin
                m_busy  <= 1'b1;
                m_beats <= (MIS && issue_split_i) ? 2 : 1;
                m_we    <= issue_we_i;
                m_type  <= issue_type_i;
                m_sext  <= issue_sign_ext_i;
                m_off   <= issue_offset_i;
                m_split <= issue_split_i;
                m_err   <= 1'b0;
            end
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk_i) begin
        chk("issue_ready", {31'h0, issue_ready_o},    {31'h0, exp_ready});
        chk("busy",        {31'h0, busy_o},           {31'h0, exp_busy});
        chk("resp_valid",  {31'h0, lsu_resp_valid_o}, {31'h0, exp_valid});
        chk("resp_err",    {31'h0, lsu_resp_err_o},   {31'h0, exp_err});
        chk("rf_we",       {31'h0, rf_we_lsu_o},      {31'h0, exp_we});
        chk("rf_wdata",    rf_wdata_lsu_o,            exp_wdata);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_issue(input logic we, input lsu_type_e t, input logic s,
                            input logic [1:0] off, input logic split);
        issue_valid_i    = 1'b1;
        issue_we_i       = we;
        issue_type_i     = t;
        issue_sign_ext_i = s;
        issue_offset_i   = off;
        issue_split_i    = split;
        step();
        issue_valid_i    = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic e);
        data_rvalid_i = 1'b1;
        data_rdata_i  = d;
        data_err_i    = e;
        #3;
    endtask

    task automatic end_beat();
        step();
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
    endtask

    initial begin
        rst_ni           = 1'b0;
        issue_valid_i    = 1'b0;
        issue_we_i       = 1'b0;
        issue_type_i     = LSU_W;
        issue_sign_ext_i = 1'b0;
        issue_offset_i   = 2'b00;
        issue_split_i    = 1'b0;
        data_rvalid_i    = 1'b0;
        data_rdata_i     = 32'h0000_0000;
        data_err_i       = 1'b0;
        repeat (2) step();
        chk("rst ready", {31'h0, issue_ready_o}, 32'd1);
        chk("rst busy",  {31'h0, busy_o},        32'd0);
        chk("rst wdata", rf_wdata_lsu_o,         32'h0000_0000);
        rst_ni = 1'b1;
        step();

        // Load word, offset 0.
        do_issue(1'b0, LSU_W, 1'b0, 2'd0, 1'b0);
        chk("lw busy", {31'h0, busy_o}, 32'd1);
        drive_beat(32'hDEAD_BEEF, 1'b0);
        chk("lw valid", {31'h0, lsu_resp_valid_o}, 32'd1);
        chk("lw we",    {31'h0, rf_we_lsu_o},      32'd1);
        chk("lw wdata", rf_wdata_lsu_o,            32'hDEAD_BEEF);
        end_beat();
        #3;
        chk("lw idle", {31'h0, busy_o}, 32'd0);

        // Load byte offset 2, signed then unsigned.
        do_issue(1'b0, LSU_B, 1'b1, 2'd2, 1'b0);
        drive_beat(32'h0080_0000, 1'b0);
        chk("lb signed", rf_wdata_lsu_o, 32'hFFFF_FF80);
        end_beat();
        do_issue(1'b0, LSU_B, 1'b0, 2'd2, 1'b0);
        drive_beat(32'h0080_0000, 1'b0);
        chk("lbu", rf_wdata_lsu_o, 32'h0000_0080);
        end_beat();

        // Split word, offset 1.
        do_issue(1'b0, LSU_W, 1'b0, 2'd1, 1'b1);
        drive_beat(32'h4433_2211, 1'b0);
`ifdef IBEX_LSU_MISALIGNED_EN
        chk("split 1st valid", {31'h0, lsu_resp_valid_o}, 32'd0);
        end_beat();
        drive_beat(32'h8877_6655, 1'b0);
        chk("split valid", {31'h0, lsu_resp_valid_o}, 32'd1);
        chk("split wdata", rf_wdata_lsu_o,            32'h5544_3322);
`else
        chk("split err",   {31'h0, lsu_resp_err_o}, 32'd1);
        chk("split we",    {31'h0, rf_we_lsu_o},    32'd0);
`endif
        end_beat();

        // Split load with error on the first beat only.
        do_issue(1'b0, LSU_W, 1'b0, 2'd2, 1'b1);
        drive_beat(32'hAAAA_AAAA, 1'b1);
`ifdef IBEX_LSU_MISALIGNED_EN
        chk("err 1st valid", {31'h0, lsu_resp_valid_o}, 32'd0);
        end_beat();
        drive_beat(32'hBBBB_BBBB, 1'b0);
`endif
        chk("err valid", {31'h0, lsu_resp_valid_o}, 32'd1);
        chk("err err",   {31'h0, lsu_resp_err_o},   32'd1);
        chk("err we",    {31'h0, rf_we_lsu_o},      32'd0);
        end_beat();

        // Signed half split at offset 3.
        do_issue(1'b0, LSU_H, 1'b1, 2'd3, 1'b1);
        drive_beat(32'h3400_0000, 1'b0);
`ifdef IBEX_LSU_MISALIGNED_EN
        end_beat();
        drive_beat(32'h0000_00F2, 1'b0);
        chk("lh3 wdata", rf_wdata_lsu_o, 32'hFFFF_F234);
`else
        chk("lh3 err", {31'h0, lsu_resp_err_o}, 32'd1);
`endif
        end_beat();

        // Store completes while the next load issues in the same cycle.
        do_issue(1'b1, LSU_W, 1'b0, 2'd0, 1'b0);
        issue_valid_i    = 1'b1;
        issue_we_i       = 1'b0;
        issue_type_i     = LSU_H;
        issue_sign_ext_i = 1'b0;
        issue_offset_i   = 2'd0;
        issue_split_i    = 1'b0;
        drive_beat(32'h1234_5678, 1'b0);
        chk("st valid", {31'h0, lsu_resp_valid_o}, 32'd1);
        chk("st we",    {31'h0, rf_we_lsu_o},      32'd0);
        chk("st ready", {31'h0, issue_ready_o},    32'd1);
        end_beat();
        issue_valid_i = 1'b0;
        drive_beat(32'h0000_ABCD, 1'b0);
        chk("lhu we",    {31'h0, rf_we_lsu_o}, 32'd1);
        chk("lhu wdata", rf_wdata_lsu_o,       32'h0000_ABCD);
        end_beat();

        // Reset mid-transaction, stray response while in reset.
        do_issue(1'b0, LSU_W, 1'b0, 2'd1, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("mid rst busy",  {31'h0, busy_o},        32'd0);
        chk("mid rst ready", {31'h0, issue_ready_o}, 32'd1);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1111_1111;
        data_err_i    = 1'b1;
        #1;
        chk("stray valid", {31'h0, lsu_resp_valid_o}, 32'd0);
        chk("stray err",   {31'h0, lsu_resp_err_o},   32'd0);
        chk("stray wdata", rf_wdata_lsu_o,            32'h0000_0000);
        step();
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        rst_ni        = 1'b1;
        step();
        chk("post rst busy", {31'h0, busy_o}, 32'd0);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
